// File: rtl/number_finder.sv
// number_finder: scans n = 0..31, emits each n whose divisibility flags
// match a latched pattern (exact or superset), with ready/valid backpressure.
module number_finder (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] pattern,
    input  logic       mode,
    input  logic       ready_in,
    output logic [4:0] num_out,
    output logic       num_valid,
    output logic       busy,
    output logic       done,
    output logic [5:0] count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_HOLD,
        S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic [4:0] r_idx;
    logic [4:0] r_pattern;
    logic       r_mode;
    logic [4:0] r_num_out;
    logic       r_num_valid;
    logic [5:0] r_count;

    logic [4:0] w_flags;
    logic       w_match;
    logic       w_last;

    // Flags: {div2, div3, div4, div5, div30}; zero is divisible by all.
    function automatic logic [4:0] flags_of(input logic [4:0] n);
        logic [4:0] f;
        f[4] = (n % 5'd2)  == 5'd0;
        f[3] = (n % 5'd3)  == 5'd0;
        f[2] = (n % 5'd4)  == 5'd0;
        f[1] = (n % 5'd5)  == 5'd0;
        f[0] = (n % 5'd30) == 5'd0;
        return f;
    endfunction

    // Match decision for the current scan index against the latched request.
    always_comb begin
        w_flags = flags_of(r_idx);
        w_last  = (r_idx == 5'd31);
        if (r_mode) begin
            w_match = ((w_flags & r_pattern) == r_pattern);
        end else begin
            w_match = (w_flags == r_pattern);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and state-decoded status outputs.
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_SCAN;
                end
            end
            S_SCAN: begin
                busy = 1'b1;
                if (w_match) begin
                    w_next = S_HOLD;
                end else if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_HOLD: begin
                busy = 1'b1;
                if (ready_in) begin
                    w_next = w_last ? S_DONE : S_SCAN;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: request latch, scan index, output register and match counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx       <= '0;
            r_pattern   <= '0;
            r_mode      <= 1'b0;
            r_num_out   <= '0;
            r_num_valid <= 1'b0;
            r_count     <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pattern <= pattern;
                        r_mode    <= mode;
                        r_count   <= '0;
                        r_idx     <= '0;
                    end
                end
                S_SCAN: begin
                    if (w_match) begin
                        r_num_out   <= r_idx;
                        r_num_valid <= 1'b1;
                    end else if (!w_last) begin
                        r_idx <= r_idx + 5'd1;
                    end
                end
                S_HOLD: begin
                    if (ready_in) begin
                        r_num_valid <= 1'b0;
                        r_count     <= r_count + 6'd1;
                        if (!w_last) begin
                            r_idx <= r_idx + 5'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered outputs drive the ports directly.
    always_comb begin
        num_out   = r_num_out;
        num_valid = r_num_valid;
        count     = r_count;
    end

endmodule

// File: tb/tb_number_finder.sv
// Self-checking bench for number_finder: directed scans plus randomized
// patterns/backpressure checked against a divisibility reference model.
module tb_number_finder;

    logic       clk;
    logic       reset;
    logic       start;
    logic [4:0] pattern;
    logic       mode;
    logic       ready_in;
    logic [4:0] num_out;
    logic       num_valid;
    logic       busy;
    logic       done;
    logic [5:0] count;

    int unsigned n_cmp;
    int unsigned n_mis;

    number_finder dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pattern   (pattern),
        .mode      (mode),
        .ready_in  (ready_in),
        .num_out   (num_out),
        .num_valid (num_valid),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: divisibility by plain arithmetic on the integer n.
    function automatic bit ref_match(input int n, input logic [4:0] p, input logic m);
        logic [4:0] f;
        f[4] = (n % 2)  == 0;
        f[3] = (n % 3)  == 0;
        f[2] = (n % 4)  == 0;
        f[1] = (n % 5)  == 0;
        f[0] = (n % 30) == 0;
        return m ? ((f & p) == p) : (f == p);
    endfunction

    // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
    // policy: 0 = always ready, 1 = random stalls, 2 = five stall cycles per item.
    task automatic run_scan(input string tag, input logic [4:0] pat, input logic md,
                            input int unsigned policy, input bit disturb,
                            output int unsigned stalls_out);
        int unsigned exp_q[$];
        int unsigned got_q[$];
        int unsigned cyc, stalls, done_cyc, busy_bad, unstable, hold_cnt;
        logic [4:0]  last_out;
        bit          prev_stall, seen_done, r;

        for (int n = 0; n < 32; n++) begin
            if (ref_match(n, pat, md)) exp_q.push_back(n);
        end

        pattern  = pat;
        mode     = md;
        start    = 1'b1;
        ready_in = 1'b0;
        @(negedge clk);
        start      = 1'b0;
        cyc        = 1;
        stalls     = 0;
        done_cyc   = 0;
        busy_bad   = 0;
        unstable   = 0;
        hold_cnt   = 0;
        last_out   = '0;
        prev_stall = 1'b0;
        seen_done  = 1'b0;

        while (!seen_done && cyc < 300) begin
            if (done === 1'b1) begin
                seen_done = 1'b1;
                done_cyc  = cyc;
                start     = 1'b0;
                chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
            end else begin
                if (busy !== 1'b1) busy_bad++;
                if (prev_stall && (num_valid !== 1'b1 || num_out !== last_out)) unstable++;
                prev_stall = 1'b0;
                if (num_valid === 1'b1) begin
                    case (policy)
                        0:       r = 1'b1;
                        1:       r = ($urandom_range(0, 2) != 0);
                        default: r = (hold_cnt >= 5);
                    endcase
                    ready_in = r;
                    if (r) begin
                        got_q.push_back(32'(num_out));
                        hold_cnt = 0;
                    end else begin
                        stalls++;
                        hold_cnt++;
                        prev_stall = 1'b1;
                        last_out   = num_out;
                    end
                end else begin
                    ready_in = 1'($urandom_range(0, 1));
                end
                if (disturb) begin
                    start   = 1'($urandom_range(0, 1));
                    pattern = 5'($urandom);
                    mode    = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                cyc++;
            end
        end

        chk({tag, "_done_seen"}, 32'(seen_done), 32'd1);
        chk({tag, "_n_emitted"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_item%0d", tag, i), got_q[i], exp_q[i]);
        end
        chk({tag, "_count"}, 32'(count), exp_q.size());
        chk({tag, "_latency"}, done_cyc, 33 + exp_q.size() + stalls);
        chk({tag, "_busy_during_scan"}, busy_bad, 32'd0);
        chk({tag, "_stable_under_stall"}, unstable, 32'd0);
        if (exp_q.size() > 0) begin
            chk({tag, "_num_out_kept"}, 32'(num_out), exp_q[exp_q.size() - 1]);
        end
        ready_in = 1'b0;
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_count_held"}, 32'(count), exp_q.size());
        stalls_out = stalls;
    endtask

    initial begin
        int unsigned st;
        int unsigned w;
        logic [4:0]  rp;
        logic        rm;

        n_cmp    = 0;
        n_mis    = 0;
        reset    = 1'b1;
        start    = 1'b0;
        pattern  = '0;
        mode     = 1'b0;
        ready_in = 1'b0;

        #1;
        chk("rst_num_out", 32'(num_out), 32'd0);
        chk("rst_num_valid", 32'(num_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(count), 32'd0);

        // Start pulsed across an edge while reset is held must be ignored.
        start = 1'b1;
        @(negedge clk);
        chk("start_in_reset_busy", 32'(busy), 32'd0);
        start = 1'b0;
        reset = 1'b0;

        run_scan("exact3", 5'b01000, 1'b0, 0, 1'b0, st);
        run_scan("super5", 5'b00010, 1'b1, 0, 1'b0, st);
        run_scan("all_flags", 5'b11111, 1'b0, 0, 1'b0, st);
        run_scan("none", 5'b00001, 1'b0, 0, 1'b0, st);
        run_scan("every", 5'b00000, 1'b1, 1, 1'b0, st);
        run_scan("backpr30", 5'b11011, 1'b0, 2, 1'b0, st);
        chk("backpr30_stalls", st, 32'd5);
        run_scan("disturb", 5'b01000, 1'b0, 1, 1'b1, st);

        // Reset mid-scan while holding the second match (9) with count = 1.
        pattern  = 5'b01000;
        mode     = 1'b0;
        start    = 1'b1;
        ready_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w     = 0;
        while (!(num_valid === 1'b1 && num_out === 5'd9) && w < 100) begin
            @(negedge clk);
            w++;
        end
        ready_in = 1'b0;
        chk("midrst_hold_item", 32'(num_out), 32'd9);
        chk("midrst_hold_count", 32'(count), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("midrst_num_out", 32'(num_out), 32'd0);
        chk("midrst_num_valid", 32'(num_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_scan("after_rst", 5'b01000, 1'b0, 0, 1'b0, st);

        for (int k = 0; k < 6; k++) begin
            rp = 5'($urandom);
            rm = 1'($urandom_range(0, 1));
            run_scan($sformatf("rand%0d", k), rp, rm, 1, 1'($urandom_range(0, 1)), st);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
